// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                |
// | Description : Two-port 128-bit line arbiter between the I-cache and      |
// |               D-cache memory-side wishbone masters and one wishbone      |
// |               master to physical memory. One transaction at a time,      |
// |               registered grant, one-cycle TURN bubble between grants.    |
// |               Build option ARB_RR_EN selects round-robin arbitration;    |
// |               otherwise D has fixed priority with a starvation limit.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-cache line port (slave)
  input  logic [ADDR_W-1:0] i_icache_adr,
  input  logic [127:0]      i_icache_dat_m,
  output logic [127:0]      o_icache_dat_s,
  input  logic [15:0]       i_icache_sel,
  input  logic              i_icache_we,
  input  logic              i_icache_stb,
  input  logic              i_icache_cyc,
  output logic              o_icache_ack,
  // D-cache line port (slave)
  input  logic [ADDR_W-1:0] i_dcache_adr,
  input  logic [127:0]      i_dcache_dat_m,
  output logic [127:0]      o_dcache_dat_s,
  input  logic [15:0]       i_dcache_sel,
  input  logic              i_dcache_we,
  input  logic              i_dcache_stb,
  input  logic              i_dcache_cyc,
  output logic              o_dcache_ack,
  // Physical memory port (master)
  output logic [ADDR_W-1:0] o_mem_adr,
  output logic [127:0]      o_mem_dat_m,
  input  logic [127:0]      i_mem_dat_s,
  output logic [15:0]       o_mem_sel,
  output logic              o_mem_we,
  output logic              o_mem_stb,
  output logic              o_mem_cyc,
  input  logic              i_mem_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_req_i;
  logic w_req_d;
  logic w_pick_i;
  logic w_grant_i;
  logic w_grant_d;

  assign w_req_i = i_icache_stb & i_icache_cyc;
  assign w_req_d = i_dcache_stb & i_dcache_cyc;

  // Read data is broadcast; only the ACKed cache samples it.
  assign o_icache_dat_s = i_mem_dat_s;
  assign o_dcache_dat_s = i_mem_dat_s;

`ifdef ARB_RR_EN
  // 1 = I was granted last; resets to 1 so D wins the first contention.
  logic r_last_gnt_i;

  // On contention the port not granted last wins; a lone requester always wins.
  always_comb w_pick_i = w_req_i & (~w_req_d | ~r_last_gnt_i);

  // Remember which port received the most recent grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt_i <= 1'b1;
    end else if (w_grant_i || w_grant_d) begin
      r_last_gnt_i <= w_grant_i;
    end
  end
`else
  localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

  logic [c_CNT_W-1:0] r_starve_cnt;

  // D wins contention unless I has been passed over STARVE_LIMIT times.
  always_comb w_pick_i = w_req_i & (~w_req_d | (r_starve_cnt == c_LIMIT));

  // Count D grants that bypass a pending I; saturate, clear on I grant or idle I.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!w_req_i || w_grant_i) begin
      r_starve_cnt <= '0;
    end else if (w_grant_d && (r_starve_cnt != c_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`endif

  // Grants are only issued from IDLE.
  assign w_grant_i = (r_state == IDLE) & w_pick_i;
  assign w_grant_d = (r_state == IDLE) & w_req_d & ~w_pick_i;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus combinational routing of the granted port to memory.
  always_comb begin
    w_state_nxt  = r_state;
    o_mem_adr    = '0;
    o_mem_dat_m  = '0;
    o_mem_sel    = '0;
    o_mem_we     = 1'b0;
    o_mem_stb    = 1'b0;
    o_mem_cyc    = 1'b0;
    o_icache_ack = 1'b0;
    o_dcache_ack = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_grant_i) begin
          w_state_nxt = GNT_I;
        end else if (w_grant_d) begin
          w_state_nxt = GNT_D;
        end
      end
      GNT_I: begin
        o_mem_adr    = i_icache_adr;
        o_mem_dat_m  = i_icache_dat_m;
        o_mem_sel    = i_icache_sel;
        o_mem_we     = i_icache_we;
        o_mem_stb    = i_icache_stb;
        o_mem_cyc    = i_icache_cyc;
        o_icache_ack = i_mem_ack;
        // Completion or abort (CYC dropped) both end the grant.
        if (i_mem_ack || !i_icache_cyc) begin
          w_state_nxt = TURN;
        end
      end
      GNT_D: begin
        o_mem_adr    = i_dcache_adr;
        o_mem_dat_m  = i_dcache_dat_m;
        o_mem_sel    = i_dcache_sel;
        o_mem_we     = i_dcache_we;
        o_mem_stb    = i_dcache_stb;
        o_mem_cyc    = i_dcache_cyc;
        o_dcache_ack = i_mem_ack;
        if (i_mem_ack || !i_dcache_cyc) begin
          w_state_nxt = TURN;
        end
      end
      TURN: begin
        // Bubble: a late memory ACK here is swallowed.
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                             |
// | Description : Self-checking bench for mem_arbiter: per-cycle vector      |
// |               table plus reset, starvation / round-robin sequences.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam logic [127:0] c_MEM_DAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] c_I_DAT   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] c_D_DAT   = 128'hDEAD_BEEF_CAFE_F00D_A5A5_5A5A_0F0F_F0F0;
  localparam logic [31:0]  c_I_LOOP  = 32'h0000_1000;
  localparam logic [31:0]  c_D_LOOP  = 32'h0000_2000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  ic_adr, dc_adr, m_adr;
  logic [127:0] ic_dat_m, ic_dat_s, dc_dat_m, dc_dat_s, m_dat_m, m_dat_s;
  logic [15:0]  ic_sel, dc_sel, m_sel;
  logic         ic_we, ic_stb, ic_cyc, ic_ack;
  logic         dc_we, dc_stb, dc_cyc, dc_ack;
  logic         m_we, m_stb, m_cyc, m_ack;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_icache_adr   (ic_adr),
    .i_icache_dat_m (ic_dat_m),
    .o_icache_dat_s (ic_dat_s),
    .i_icache_sel   (ic_sel),
    .i_icache_we    (ic_we),
    .i_icache_stb   (ic_stb),
    .i_icache_cyc   (ic_cyc),
    .o_icache_ack   (ic_ack),
    .i_dcache_adr   (dc_adr),
    .i_dcache_dat_m (dc_dat_m),
    .o_dcache_dat_s (dc_dat_s),
    .i_dcache_sel   (dc_sel),
    .i_dcache_we    (dc_we),
    .i_dcache_stb   (dc_stb),
    .i_dcache_cyc   (dc_cyc),
    .o_dcache_ack   (dc_ack),
    .o_mem_adr      (m_adr),
    .o_mem_dat_m    (m_dat_m),
    .i_mem_dat_s    (m_dat_s),
    .o_mem_sel      (m_sel),
    .o_mem_we       (m_we),
    .o_mem_stb      (m_stb),
    .o_mem_cyc      (m_cyc),
    .i_mem_ack      (m_ack)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One record per clock: port requests, memory ACK, expected memory/ACK view.
  typedef struct {
    logic        i;
    logic [31:0] ia;
    logic        d;
    logic [31:0] da;
    logic        ma;
    logic        es;
    logic [31:0] eadr;
    logic        eia;
    logic        eda;
  } vec_t;

  vec_t v [23];

  // Both ports request continuously; check the order in which memory is granted.
  task automatic run_grants(input int n, input string seq);
    int  got  = 0;
    int  cyc  = 0;
    byte g;
    while (got < n && cyc < 200) begin
      @(posedge clk); #1;
      m_ack = 1'b0;
      cyc++;
      if (m_stb) begin
        g = (m_adr == c_I_LOOP) ? "I" : "D";
        chk($sformatf("grant%0d port", got), 128'(g), 128'(seq[got]));
        if (g == "D") begin
          chk($sformatf("grant%0d d we", got), 128'(m_we), 128'(1'b1));
          chk($sformatf("grant%0d d sel", got), 128'(m_sel), 128'(16'hFFFF));
          chk($sformatf("grant%0d d dat_m", got), m_dat_m, c_D_DAT);
        end
        m_ack = 1'b1;
        got++;
        @(negedge clk);
        chk($sformatf("grant%0d i ack", got - 1), 128'(ic_ack), 128'(g == "I"));
        chk($sformatf("grant%0d d ack", got - 1), 128'(dc_ack), 128'(g == "D"));
      end
    end
    if (got < n) chk("grant timeout", 128'(got), 128'(n));
    @(posedge clk); #1;
    m_ack = 1'b0;
  endtask

  initial begin
    // Lone I read at 0x40 with memory ACK three cycles after STB.
    v[0]  = '{1, 32'h40,  0, 32'h0,   0, 0, 32'h0,   0, 0};
    v[1]  = '{1, 32'h40,  0, 32'h0,   0, 1, 32'h40,  0, 0};
    v[2]  = '{1, 32'h40,  0, 32'h0,   0, 1, 32'h40,  0, 0};
    v[3]  = '{1, 32'h40,  0, 32'h0,   0, 1, 32'h40,  0, 0};
    v[4]  = '{1, 32'h40,  0, 32'h0,   1, 1, 32'h40,  1, 0};
    v[5]  = '{0, 32'h40,  0, 32'h0,   0, 0, 32'h0,   0, 0};
    v[6]  = '{0, 32'h40,  0, 32'h0,   0, 0, 32'h0,   0, 0};
    // Simultaneous requests: D first, TURN, then I.
    v[7]  = '{1, 32'h100, 1, 32'h200, 0, 0, 32'h0,   0, 0};
    v[8]  = '{1, 32'h100, 1, 32'h200, 0, 1, 32'h200, 0, 0};
    v[9]  = '{1, 32'h100, 1, 32'h200, 1, 1, 32'h200, 0, 1};
    v[10] = '{1, 32'h100, 0, 32'h200, 0, 0, 32'h0,   0, 0};
    v[11] = '{1, 32'h100, 0, 32'h200, 0, 0, 32'h0,   0, 0};
    v[12] = '{1, 32'h100, 0, 32'h200, 1, 1, 32'h100, 1, 0};
    v[13] = '{0, 32'h100, 0, 32'h200, 0, 0, 32'h0,   0, 0};
    v[14] = '{0, 32'h100, 0, 32'h200, 0, 0, 32'h0,   0, 0};
    // D abort with late memory ACK, then a clean D transaction.
    v[15] = '{0, 32'h0,   1, 32'h300, 0, 0, 32'h0,   0, 0};
    v[16] = '{0, 32'h0,   1, 32'h300, 0, 1, 32'h300, 0, 0};
    v[17] = '{0, 32'h0,   0, 32'h300, 0, 0, 32'h300, 0, 0};
    v[18] = '{0, 32'h0,   0, 32'h300, 1, 0, 32'h0,   0, 0};
    v[19] = '{0, 32'h0,   1, 32'h340, 0, 0, 32'h0,   0, 0};
    v[20] = '{0, 32'h0,   1, 32'h340, 0, 1, 32'h340, 0, 0};
    v[21] = '{0, 32'h0,   1, 32'h340, 1, 1, 32'h340, 0, 1};
    v[22] = '{0, 32'h0,   0, 32'h340, 0, 0, 32'h0,   0, 0};

    rst_n = 1'b0;
    ic_adr = '0; ic_dat_m = c_I_DAT; ic_sel = 16'hFFFF; ic_we = 1'b0; ic_stb = 1'b0; ic_cyc = 1'b0;
    dc_adr = '0; dc_dat_m = c_D_DAT; dc_sel = 16'hFFFF; dc_we = 1'b1; dc_stb = 1'b0; dc_cyc = 1'b0;
    m_dat_s = c_MEM_DAT; m_ack = 1'b0;

    // Reset state.
    #2;
    chk("reset mem_stb", 128'(m_stb), 128'(1'b0));
    chk("reset mem_cyc", 128'(m_cyc), 128'(1'b0));
    chk("reset i_ack", 128'(ic_ack), 128'(1'b0));
    chk("reset d_ack", 128'(dc_ack), 128'(1'b0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    for (int k = 0; k < 23; k++) begin
      @(posedge clk); #1;
      ic_stb = v[k].i; ic_cyc = v[k].i; ic_adr = v[k].ia;
      dc_stb = v[k].d; dc_cyc = v[k].d; dc_adr = v[k].da;
      m_ack  = v[k].ma;
      @(negedge clk);
      chk($sformatf("v%0d mem_stb", k), 128'(m_stb), 128'(v[k].es));
      chk($sformatf("v%0d mem_cyc", k), 128'(m_cyc), 128'(v[k].es));
      chk($sformatf("v%0d mem_adr", k), 128'(m_adr), 128'(v[k].eadr));
      chk($sformatf("v%0d i_ack", k), 128'(ic_ack), 128'(v[k].eia));
      chk($sformatf("v%0d d_ack", k), 128'(dc_ack), 128'(v[k].eda));
      if (v[k].eia) chk($sformatf("v%0d i_dat_s", k), ic_dat_s, c_MEM_DAT);
      if (v[k].eda) chk($sformatf("v%0d d_dat_s", k), dc_dat_s, c_MEM_DAT);
    end

    // Reset while D is mid-grant: outputs drop at once, nothing resumes.
    @(posedge clk); #1;
    m_ack = 1'b0;
    dc_stb = 1'b1; dc_cyc = 1'b1; dc_adr = 32'h500;
    @(posedge clk);
    @(negedge clk);
    chk("rst pre mem_stb", 128'(m_stb), 128'(1'b1));
    #2;
    m_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst mem_stb", 128'(m_stb), 128'(1'b0));
    chk("rst mem_cyc", 128'(m_cyc), 128'(1'b0));
    chk("rst d_ack", 128'(dc_ack), 128'(1'b0));
    @(negedge clk);
    dc_stb = 1'b0; dc_cyc = 1'b0; m_ack = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("post rst%0d mem_stb", k), 128'(m_stb), 128'(1'b0));
      chk($sformatf("post rst%0d d_ack", k), 128'(dc_ack), 128'(1'b0));
    end

    // Continuous contention from both ports.
    @(posedge clk); #1;
    ic_stb = 1'b1; ic_cyc = 1'b1; ic_adr = c_I_LOOP;
    dc_stb = 1'b1; dc_cyc = 1'b1; dc_adr = c_D_LOOP;
`ifdef ARB_RR_EN
    run_grants(8, "DIDIDIDI");
`else
    run_grants(5, "DDDDI");
`endif
    ic_stb = 1'b0; ic_cyc = 1'b0;
    dc_stb = 1'b0; dc_cyc = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
